// File: rtl/mem_phase_ctrl.sv
// Four-phase dual-rail sequencer for the memory address path.
// Alternates fetch/execute DATA wavefronts with NULL spacers, owns the PC and traps stalled handshakes.
module mem_phase_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       jump_valid,
    input  logic [3:0] jump_addr,
    input  logic       ack,
    input  logic       clr,
    output logic       PH0_t,
    output logic       PH0_f,
    output logic [3:0] PC_t,
    output logic [3:0] PC_f,
    output logic       busy,
    output logic       fault
);
    // state  | meaning
    // IDLE   | all rails NULL, waits for run with ack low (no timeout)
    // F_DATA | fetch wavefront: PH0_t=1, PC rails carry pc; waits ack high
    // F_NULL | spacer after fetch; waits ack low
    // X_DATA | execute wavefront: PH0_f=1, PC rails NULL; waits ack high
    // X_NULL | spacer after execute; run picks next pair or idle
    // FAULT  | handshake timeout; all NULL until clr
    typedef enum logic [2:0] {
        S_IDLE,
        S_F_DATA,
        S_F_NULL,
        S_X_DATA,
        S_X_NULL,
        S_FAULT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] pc;
    logic [7:0] cnt;
    logic       wait_expired;

    assign wait_expired = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            PH0_t <= 1'b0;
            PH0_f <= 1'b0;
            PC_t  <= '0;
            PC_f  <= '0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run && !ack) begin
                        state <= S_F_DATA;
                        cnt   <= '0;
                        PH0_t <= 1'b1;
                        PC_t  <= pc;
                        PC_f  <= ~pc;
                        busy  <= 1'b1;
                    end
                end
                S_F_DATA: begin
                    if (ack) begin
                        state <= S_F_NULL;
                        cnt   <= '0;
                        pc    <= pc + 4'd1;
                        PH0_t <= 1'b0;
                        PC_t  <= '0;
                        PC_f  <= '0;
                    end else if (wait_expired) begin
                        state <= S_FAULT;
                        cnt   <= '0;
                        PH0_t <= 1'b0;
                        PH0_f <= 1'b0;
                        PC_t  <= '0;
                        PC_f  <= '0;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_F_NULL: begin
                    if (!ack) begin
                        state <= S_X_DATA;
                        cnt   <= '0;
                        PH0_f <= 1'b1;
                    end else if (wait_expired) begin
                        state <= S_FAULT;
                        cnt   <= '0;
                        PH0_t <= 1'b0;
                        PH0_f <= 1'b0;
                        PC_t  <= '0;
                        PC_f  <= '0;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_X_DATA: begin
                    if (ack) begin
                        state <= S_X_NULL;
                        cnt   <= '0;
                        PH0_f <= 1'b0;
                        // a jump replaces the increment taken at the end of fetch
                        if (jump_valid) begin
                            pc <= jump_addr;
                        end
                    end else if (wait_expired) begin
                        state <= S_FAULT;
                        cnt   <= '0;
                        PH0_t <= 1'b0;
                        PH0_f <= 1'b0;
                        PC_t  <= '0;
                        PC_f  <= '0;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_X_NULL: begin
                    if (!ack) begin
                        cnt <= '0;
                        if (run) begin
                            state <= S_F_DATA;
                            PH0_t <= 1'b1;
                            PC_t  <= pc;
                            PC_f  <= ~pc;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (wait_expired) begin
                        state <= S_FAULT;
                        cnt   <= '0;
                        PH0_t <= 1'b0;
                        PH0_f <= 1'b0;
                        PC_t  <= '0;
                        PC_f  <= '0;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FAULT: begin
                    if (clr) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    PH0_t <= 1'b0;
                    PH0_f <= 1'b0;
                    PC_t  <= '0;
                    PC_f  <= '0;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_phase_ctrl.sv
// Scoreboard bench for mem_phase_ctrl: fetch addresses predicted from the PC rules, checked on each new fetch.
module tb_mem_phase_ctrl;
    logic       clk;
    logic       rst_n;
    logic       run;
    logic       jump_valid;
    logic [3:0] jump_addr;
    logic       ack;
    logic       clr;
    logic       PH0_t;
    logic       PH0_f;
    logic [3:0] PC_t;
    logic [3:0] PC_f;
    logic       busy;
    logic       fault;

    mem_phase_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .ack        (ack),
        .clr        (clr),
        .PH0_t      (PH0_t),
        .PH0_f      (PH0_f),
        .PC_t       (PC_t),
        .PC_f       (PC_f),
        .busy       (busy),
        .fault      (fault)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fetch_cnt = 0;
    int         last_fetch_cyc = -1;
    logic [3:0] exp_q[$];
    logic [3:0] m_next;
    bit         auto_ack;
    bit         jump_rand;
    bit         noise;
    bit         noise_clr;
    bit         chk_period;
    int         force_from;
    logic [3:0] force_to;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_fetches(input int n);
        int target;
        int budget;
        target = fetch_cnt + n;
        budget = n * 4 + 40;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fetch_cnt >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_fetches: only %0d of %0d fetches seen", fetch_cnt - target + n, n);
    endtask

    task automatic wait_pc(input logic [3:0] v);
        for (int i = 0; i < 120; i++) begin
            if (PH0_t === 1'b1 && PC_t === v) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_pc: fetch of %0d not seen, got PC_t=%0h", v, PC_t);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0 && {PH0_t, PH0_f, PC_t, PC_f} === 10'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy=%0b still after budget", busy);
    endtask

    // Memory-side completion model: ack follows "any rail high" one cycle late.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_ack) ack = PH0_t | PH0_f | (|PC_t) | (|PC_f);
            if (noise_clr) clr = 1'($urandom_range(0, 1));
        end
    end

    // Jump driver and reference PC model: next fetch = jump target if taken, else previous fetch + 1 mod 16.
    initial begin
        bit         in_x;
        bit         jv;
        logic [3:0] ja;
        in_x = 1'b0;
        jump_valid = 1'b0;
        jump_addr = 4'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                in_x = 1'b0;
            end else if (PH0_f === 1'b1) begin
                if (!in_x) begin
                    in_x = 1'b1;
                    ja = 4'($urandom_range(0, 15));
                    jv = 1'b0;
                    if (force_from >= 0 && m_next == 4'(force_from)) begin
                        jv = 1'b1;
                        ja = force_to;
                    end else if (jump_rand) begin
                        jv = ($urandom_range(0, 3) == 0);
                    end
                    jump_valid = jv;
                    jump_addr = ja;
                    m_next = jv ? ja : 4'((m_next + 1) % 16);
                    exp_q.push_back(m_next);
                end
            end else begin
                in_x = 1'b0;
                jump_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                jump_addr = 4'($urandom_range(0, 15));
            end
        end
    end

    // Monitor: rail invariants every cycle; scoreboard pop on every new fetch wavefront.
    initial begin
        logic       p_t;
        logic       p_f;
        logic [3:0] e;
        logic [3:0] ne;
        p_t = 1'b0;
        p_f = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("rail_pair_11", {PH0_t & PH0_f, PC_t & PC_f}, 0);
                check("ph0_data_to_data", (p_t & PH0_f) | (p_f & PH0_t), 0);
                if (PH0_t !== 1'b1) check("pc_null_outside_fetch", {PC_t, PC_f}, 0);
                if (PH0_t === 1'b1 && p_t !== 1'b1) begin
                    fetch_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected: got PC_t=%0h, expected no fetch", PC_t);
                    end else begin
                        e = exp_q.pop_front();
                        ne = ~e;
                        check("fetch_pc_t", PC_t, e);
                        check("fetch_pc_f", PC_f, ne);
                    end
                    if (chk_period && last_fetch_cyc >= 0)
                        check("fetch_period", cyc - last_fetch_cyc, 4);
                    last_fetch_cyc = cyc;
                end
            end
            p_t = PH0_t;
            p_f = PH0_f;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b1;
        clr = 1'b0;
        ack = 1'b0;
        auto_ack = 1'b0;
        jump_rand = 1'b0;
        noise = 1'b0;
        noise_clr = 1'b0;
        chk_period = 1'b0;
        force_from = -1;
        force_to = 4'd0;
        m_next = 4'd0;

        // reset held with run high and ack toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            ack = ~ack;
            #2;
            check("reset_outputs", {PH0_t, PH0_f, PC_t, PC_f, busy, fault}, 0);
        end
        ack = 1'b0;
        exp_q.push_back(4'd0);
        auto_ack = 1'b1;
        chk_period = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // free run through the 15->0 wrap
        wait_fetches(18);

        // jump to 9 on the execute after fetching 3
        force_from = 3;
        force_to = 4'd9;
        wait_fetches(4);
        force_from = -1;

        // randomized jumps, with jump_valid and clr noise where they must be ignored
        jump_rand = 1'b1;
        noise = 1'b1;
        noise_clr = 1'b1;
        wait_fetches(60);
        jump_rand = 1'b0;
        noise = 1'b0;
        noise_clr = 1'b0;
        clr = 1'b0;

        // stop: drop run in F_NULL after fetching 5
        wait_pc(4'd5);
        @(posedge clk); #1;
        run = 1'b0;
        chk_period = 1'b0;
        last_fetch_cyc = -1;
        @(posedge clk); #1;
        check("stop_exec_data", PH0_f, 1);
        @(posedge clk); #1;
        check("stop_exec_null_busy", {busy, PH0_t, PH0_f}, 3'b100);
        @(posedge clk); #1;
        check("stop_idle_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stop_idle_hold", {busy, PH0_t, PH0_f, fault}, 0);
        end
        run = 1'b1;
        wait_fetches(1);
        run = 1'b0;
        wait_idle();

        // expected ack arriving on the last allowed edge wins over the timeout
        auto_ack = 1'b0;
        ack = 1'b0;
        run = 1'b1;
        @(posedge clk); #1;
        check("prio_enter_fetch", PH0_t, 1);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
        end
        check("prio_still_fetch", {PH0_t, fault}, 2'b10);
        ack = 1'b1;
        @(posedge clk); #1;
        check("prio_no_fault", {fault, busy, PH0_t}, 3'b010);
        ack = 1'b0;
        auto_ack = 1'b1;
        wait_fetches(1);
        run = 1'b0;
        wait_idle();

        // timeout: ack held low in F_DATA for 15 cycles
        auto_ack = 1'b0;
        ack = 1'b0;
        run = 1'b1;
        @(posedge clk); #1;
        check("timeout_enter_fetch", PH0_t, 1);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 14) check("timeout_not_yet", {fault, PH0_t}, 2'b01);
        end
        check("timeout_fault", {fault, busy}, 2'b10);
        check("timeout_rails_null", {PH0_t, PH0_f, PC_t, PC_f}, 0);
        exp_q.push_back(m_next);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("fault_held", fault, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_to_idle", {fault, busy}, 0);
        auto_ack = 1'b1;
        run = 1'b1;
        wait_fetches(1);

        // mid-operation reset during X_DATA with pc=7
        wait_pc(4'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset_in_exec", {PH0_f, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {PH0_t, PH0_f, PC_t, PC_f, busy, fault}, 0);
        exp_q.delete();
        m_next = 4'd0;
        exp_q.push_back(4'd0);
        last_fetch_cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetches(2);
        run = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
